// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline stall/flush controller: FSM encodings,
// hazard priorities and the bundle of pipeline-register controls.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_INIT     = 2'b00,
    ST_RUN      = 2'b01,
    ST_MEM_WAIT = 2'b10,
    ST_FAULT    = 2'b11
  } state_t;

  // Lower numeric value is not meaningful; priority lives in classify_hazard.
  typedef enum logic [1:0] {
    HZ_NONE     = 2'd0,
    HZ_FREEZE   = 2'd1,
    HZ_REDIRECT = 2'd2,
    HZ_LOAD_USE = 2'd3
  } hazard_t;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
    logic memwb_flush;
  } ctrl_t;

  localparam ctrl_t CTRL_RUN    = ctrl_t'(9'b11111_0000);
  localparam ctrl_t CTRL_SCRUB  = ctrl_t'(9'b00000_1111);
  localparam ctrl_t CTRL_FREEZE = ctrl_t'(9'b00001_0001);

  function automatic hazard_t classify_hazard(input logic frozen,
                                              input logic redirect,
                                              input logic load_use);
    if (frozen)        return HZ_FREEZE;
    else if (redirect) return HZ_REDIRECT;
    else if (load_use) return HZ_LOAD_USE;
    else               return HZ_NONE;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard inputs from the pipeline stages and the control/counter outputs
// of the stall/flush controller.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 16
);
  logic [REG_ADDR_WIDTH-1:0] id_rs1;
  logic [REG_ADDR_WIDTH-1:0] id_rs2;
  logic                      id_uses_rs1;
  logic                      id_uses_rs2;
  logic [REG_ADDR_WIDTH-1:0] ex_rd;
  logic                      ex_mem_read;
  logic                      ex_redirect;
  logic                      mem_req;
  logic                      mem_ready;
  logic                      fault_clear;
  logic                      pc_en;
  logic                      ifid_en, idex_en, exmem_en, memwb_en;
  logic                      ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic                      fault;
  logic [CNT_WIDTH-1:0]      stall_cnt;
  logic [CNT_WIDTH-1:0]      flush_cnt;

  // master: the controller side
  modport master (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
           ex_redirect, mem_req, mem_ready, fault_clear,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, memwb_flush,
           fault, stall_cnt, flush_cnt
  );

  modport slave (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
           ex_redirect, mem_req, mem_ready, fault_clear,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, memwb_flush,
           fault, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-low reset.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);
  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (!reset)
      count_reg <= '0;
    else if (inc && (count_reg != '1))
      count_reg <= count_reg + 1'b1;
  end

  assign count = count_reg;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline: post-reset scrub,
// load-use stalls, redirect squashes, data-memory freezes and timeout fault.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int INIT_CYCLES    = 2,
  parameter int WAIT_TIMEOUT   = 255,
  parameter int CNT_WIDTH      = 16
) (
  input logic                   clk,
  input logic                   reset,
  pipeline_hazard_ctrl_if.master bus
);
  localparam int INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam int WAIT_W = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

  state_t              state_reg, state_next;
  logic [INIT_W-1:0]   init_cnt_reg, init_cnt_next;
  logic [WAIT_W-1:0]   wait_cnt_reg, wait_cnt_next;
  ctrl_t               ctrl;
  hazard_t             hazard;
  logic                frozen;
  logic                fault;
  logic                load_use;
  logic                stall_inc;
  logic                flush_inc;
  logic [REG_ADDR_WIDTH-1:0] rs1, rs2, rd;

  assign rs1 = bus.id_rs1;
  assign rs2 = bus.id_rs2;
  assign rd  = bus.ex_rd;

  // x0 is never a real dependency, so a load into it cannot cause a stall.
  assign load_use = bus.ex_mem_read && (rd != '0) &&
                    ((bus.id_uses_rs1 && (rs1 == rd)) ||
                     (bus.id_uses_rs2 && (rs2 == rd)));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg    <= ST_INIT;
      init_cnt_reg <= '0;
      wait_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      init_cnt_reg <= init_cnt_next;
      wait_cnt_reg <= wait_cnt_next;
    end
  end

  always_comb begin
    ctrl          = CTRL_RUN;
    fault         = 1'b0;
    frozen        = 1'b0;
    hazard        = HZ_NONE;
    state_next    = state_reg;
    init_cnt_next = init_cnt_reg;
    wait_cnt_next = wait_cnt_reg;
    case (state_reg)
      ST_INIT: begin
        ctrl = CTRL_SCRUB;
        if (init_cnt_reg == INIT_LAST) begin
          state_next    = ST_RUN;
          init_cnt_next = '0;
        end else begin
          init_cnt_next = init_cnt_reg + 1'b1;
        end
      end
      ST_RUN, ST_MEM_WAIT: begin
        // Once waiting, only mem_ready matters; mem_req is already committed.
        frozen = (state_reg == ST_RUN) ? (bus.mem_req && !bus.mem_ready)
                                       : !bus.mem_ready;
        hazard = classify_hazard(frozen, bus.ex_redirect, load_use);
        case (hazard)
          HZ_FREEZE:   ctrl = CTRL_FREEZE;
          HZ_REDIRECT: begin
            ctrl.ifid_flush = 1'b1;
            ctrl.idex_flush = 1'b1;
          end
          HZ_LOAD_USE: begin
            ctrl.pc_en      = 1'b0;
            ctrl.ifid_en    = 1'b0;
            ctrl.idex_flush = 1'b1;
          end
          default: ;
        endcase
        if (hazard == HZ_FREEZE) begin
          if (state_reg == ST_RUN) begin
            state_next    = ST_MEM_WAIT;
            wait_cnt_next = WAIT_ONE;
          end else if (wait_cnt_reg == WAIT_LAST) begin
            state_next    = ST_FAULT;
            wait_cnt_next = '0;
          end else begin
            wait_cnt_next = wait_cnt_reg + 1'b1;
          end
        end else begin
          state_next    = ST_RUN;
          wait_cnt_next = '0;
        end
      end
      ST_FAULT: begin
        ctrl  = CTRL_SCRUB;
        fault = 1'b1;
        if (bus.fault_clear) begin
          state_next    = ST_INIT;
          init_cnt_next = '0;
        end
      end
      default: state_next = ST_INIT;
    endcase
  end

  assign stall_inc = !ctrl.pc_en &&
                     ((state_reg == ST_RUN) || (state_reg == ST_MEM_WAIT));
  assign flush_inc = (hazard == HZ_REDIRECT);

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk(clk), .reset(reset), .inc(stall_inc), .count(bus.stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk(clk), .reset(reset), .inc(flush_inc), .count(bus.flush_cnt)
  );

  assign bus.pc_en       = ctrl.pc_en;
  assign bus.ifid_en     = ctrl.ifid_en;
  assign bus.idex_en     = ctrl.idex_en;
  assign bus.exmem_en    = ctrl.exmem_en;
  assign bus.memwb_en    = ctrl.memwb_en;
  assign bus.ifid_flush  = ctrl.ifid_flush;
  assign bus.idex_flush  = ctrl.idex_flush;
  assign bus.exmem_flush = ctrl.exmem_flush;
  assign bus.memwb_flush = ctrl.memwb_flush;
  assign bus.fault       = fault;
endmodule
